hpm_counter_bank: RTL and testbench
===================================

Name: hpm_counter_bank

Overview:
Parametrised bank of RISC-V hardware performance monitor counters (mhpmcounter3..3+N-1) with Sscofpmf-style overflow and privilege-mode filtering. Sits beside the CSR file and serves its SRAM-like CSR port. Events arrive from the pipeline as a pre-decoded vector. Unlike the previous generation, it has:
- multi-increment per cycle (e.g. several commit ports retiring the same event);
- configurable counter width and count;
- per-counter overflow flag and interrupt pulse.

Parameters:
NumCounters, 6, implemented counters (1..29); counter k maps to CSR index 3+k
CntWidth, 64, counter width in bits (32..64)
NumEvents, 32, size of event vector; selector values 1..NumEvents-1 are valid
IncWidth, 2, width of per-event increment (max increment 2^IncWidth-1 per cycle)
XLEN, 64, CSR data width (32 or 64)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
addr_i  in  12  CSR address
we_i  in  1  CSR write strobe
data_i  in  XLEN  CSR write data
data_o  out  XLEN  CSR read data, combinational from addr_i
access_err_o  out  1  illegal access this cycle, combinational
event_inc_i  in  NumEvents*IncWidth  per-event increment this cycle; event 0 is unused
priv_lvl_i  in  2  current privilege (3=M, 1=S, 0=U)
debug_mode_i  in  1  core in debug mode
inhibit_i  in  NumCounters  mcountinhibit bits [3+NumCounters-1:3]
ovf_o  out  NumCounters  current OF flags
ovf_irq_o  out  1  one-cycle pulse on any OF 0->1 transition (registered)

Behaviour:
Reset:
- All counters 0, selectors 0, OF/MINH/SINH/UINH 0.
- ovf_irq_o 0.
- Any operation in flight is discarded; reset dominates writes and increments in the same cycle.

Per-counter state:
- cnt[CntWidth-1:0], sel[7:0], OF, MINH, SINH, UINH.

Increment:
- inc_k = event_inc_i[sel_k] if 1 <= sel_k < NumEvents, else 0.
- inc_k is forced to 0 if any of the following holds:
  - inhibit_i[k];
  - debug_mode_i;
  - priv filter: MINH and priv=3, SINH and priv=1, or UINH and priv=0.
- cnt_k <= cnt_k + inc_k, modulo 2^CntWidth.
- A carry out of bit CntWidth-1 sets OF_k (sticky).
- ovf_irq_o is asserted the next cycle iff some OF_k went 0->1. An already-set OF raises no new pulse.

CSR map (counter k = CSR index 3+k):
- mhpmcounter 0xB03+k and hpmcounter 0xC03+k: read cnt[XLEN-1:0], zero-extended if CntWidth<XLEN.
- mhpmcounterh 0xB83+k and hpmcounterh 0xC83+k: valid only when XLEN=32; read cnt[63:32], bits at or above CntWidth read 0.
- mhpmevent 0x323+k:
  - XLEN=64: [63]=OF, [62]=MINH, [61]=SINH, [60]=UINH, [7:0]=sel.
  - XLEN=32: holds [7:0] only.
- mhpmeventh 0x723+k (XLEN=32 only): [31:28]=OF, MINH, SINH, UINH.
- Unlisted event bits read 0 and ignore writes.
- Software may set or clear OF by write.

Writes:
- mhpmcounter(h) replaces the addressed half.
- A write to counter k has priority over its increment in that cycle: the written value is stored, the increment is lost, and OF is not set by that increment.
- A write to the event register in the same cycle as an overflow stores the written OF value.
- Other counters still increment normally.

Unimplemented counters:
- Indices in 3..31 with k >= NumCounters read 0, ignore writes, no error.

access_err_o = 1 for:
- any write to 0xC03..0xC1F or 0xC83..0xC9F;
- any access to a *h / mhpmeventh address when XLEN=64.

On an erroring access: state unchanged, data_o=0. Addresses outside all ranges give data_o=0 and access_err_o=0.

Timing:
- Write takes effect on the next rising edge.
- A read in the same cycle returns the old value.

Decomposition:
Shared package:
- CSR base address constants (MHPMCOUNTER3, MHPMCOUNTER3H, MHPMEVENT3, MHPMEVENT3H, HPMCOUNTER3, HPMCOUNTER3H).
- Event-field bit positions.
- Event selector enumeration (same encodings as the current event list, extended to 8 bits).
- hpm_event_cfg_t struct {of, minh, sinh, uinh, sel}.

Sub-module hpm_counter_slice:
- Holds one counter with its cfg register, increment/filter/overflow logic and write-priority logic.
- Instantiated NumCounters times.
- The top holds address decode, read mux and the irq register.

Test Plan:
1. Counter wrap (XLEN=64, CntWidth=64): write mhpmcounter3=0xFFFF_FFFF_FFFF_FFFE, sel=5, event_inc[5]=3 for one cycle -> cnt=1, ovf_o[0]=1, ovf_irq_o high exactly one cycle; a second wrap while OF=1 gives no pulse.
2. Narrow counter (CntWidth=40, XLEN=32): preload 0xFF_FFFF_FFFF via low then high half, inc 1 -> read low=0 and high=0, OF set; high-half bits 31:8 always read 0.
3. Write/increment collision: sel0=1, event_inc[1]=2 every cycle, write mhpmcounter3=100 -> next-cycle read 100, following cycle 102; counter 1 with the same sel keeps incrementing undisturbed.
4. Filtering: MINH=1, priv=3 with events -> no count; priv=0 -> counts. Same check with inhibit_i[0]=1 and with debug_mode_i=1 -> frozen.
5. Access errors: with XLEN=64, read 0xB83 -> access_err_o=1, data_o=0. Write 0xC03 -> access_err_o=1 and counter unchanged. Access 0xB1F with NumCounters=6 -> reads 0, no error.
6. Reset mid-count: assert rst_i for 1 cycle while events and a write are active -> all counters, selectors, OF 0 and ovf_irq_o=0 next cycle.

Source files
------------

// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the HPM counter bank: CSR base addresses, event
// register field positions, event selector encodings and the per-counter config.
package hpm_counter_bank_pkg;

   localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] MHPMEVENT3    = 12'h323;
   localparam logic [11:0] MHPMEVENT3H   = 12'h723;
   localparam logic [11:0] HPMCOUNTER3   = 12'hC03;
   localparam logic [11:0] HPMCOUNTER3H  = 12'hC83;

   // Flag positions in mhpmevent (RV64) and in mhpmeventh (RV32).
   localparam int EVT_OF_BIT    = 63;
   localparam int EVT_MINH_BIT  = 62;
   localparam int EVT_SINH_BIT  = 61;
   localparam int EVT_UINH_BIT  = 60;
   localparam int EVTH_OF_BIT   = 31;
   localparam int EVTH_MINH_BIT = 30;
   localparam int EVTH_SINH_BIT = 29;
   localparam int EVTH_UINH_BIT = 28;
   localparam int EVT_SEL_MSB   = 7;

   typedef enum logic [7:0] {
      HPM_EV_NONE        = 8'd0,
      HPM_EV_L1I_MISS    = 8'd1,
      HPM_EV_L1D_MISS    = 8'd2,
      HPM_EV_ITLB_MISS   = 8'd3,
      HPM_EV_DTLB_MISS   = 8'd4,
      HPM_EV_LOAD        = 8'd5,
      HPM_EV_STORE       = 8'd6,
      HPM_EV_EXCEPTION   = 8'd7,
      HPM_EV_SYSCALL     = 8'd8,
      HPM_EV_BRANCH      = 8'd9,
      HPM_EV_BRANCH_MISS = 8'd10,
      HPM_EV_JUMP        = 8'd11,
      HPM_EV_CALL        = 8'd12,
      HPM_EV_RETURN      = 8'd13,
      HPM_EV_SB_FULL     = 8'd14,
      HPM_EV_IF_EMPTY    = 8'd15
   } hpm_event_sel_e;

   typedef struct packed {
      logic       of;
      logic       minh;
      logic       sinh;
      logic       uinh;
      logic [7:0] sel;
   } hpm_event_cfg_t;

   // A CSR block spans one 32-entry page; only indices 3..31 belong to the HPM bank.
   function automatic logic page_hit(input logic [11:0] addr, input logic [11:0] base);
      return (addr[11:5] == base[11:5]) && (addr[4:0] >= 5'd3);
   endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// SRAM-like CSR port between the CSR file (master) and the HPM bank (slave).
interface hpm_counter_bank_if #(
   parameter int XLEN = 64
);
   logic [11:0]     addr_i;
   logic            we_i;
   logic [XLEN-1:0] data_i;
   logic [XLEN-1:0] data_o;
   logic            access_err_o;

   modport master (
      output addr_i, we_i, data_i,
      input  data_o, access_err_o
   );

   modport slave (
      input  addr_i, we_i, data_i,
      output data_o, access_err_o
   );
endinterface

// File: rtl/hpm_counter_slice.sv
// One performance counter with its event config: event select, privilege
// filtering, sticky overflow and CSR write priority over the increment.
module hpm_counter_slice
   import hpm_counter_bank_pkg::*;
#(
   parameter int CntWidth  = 64,
   parameter int NumEvents = 32,
   parameter int IncWidth  = 2,
   parameter int XLEN      = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NumEvents*IncWidth-1:0] event_inc,
   input  logic [1:0]                    priv_lvl,
   input  logic                          debug_mode,
   input  logic                          inhibit,
   input  logic                          cnt_lo_we,
   input  logic                          cnt_hi_we,
   input  logic                          evt_we,
   input  logic                          evt_hi_we,
   input  logic [XLEN-1:0]               wdata,
   output logic [CntWidth-1:0]           cnt,
   output hpm_event_cfg_t                cfg,
   output logic                          of_rise
);

   localparam int         SelW     = (NumEvents > 1) ? $clog2(NumEvents) : 1;
   localparam int         FlagTop  = (XLEN == 64) ? EVT_OF_BIT : EVTH_OF_BIT;
   localparam logic [8:0] SelLimit = 9'(NumEvents);

   logic [IncWidth-1:0] ev_inc [NumEvents];
   logic                sel_valid;
   logic                blocked;
   logic                cnt_we;
   logic                flag_we;
   logic                carry;
   logic [IncWidth-1:0] inc;
   logic [CntWidth:0]   sum;
   logic [63:0]         wr_value;
   logic [CntWidth-1:0] cnt_next;
   hpm_event_cfg_t      cfg_next;
   logic                unused_bits;

   always_comb begin
      for (int e = 0; e < NumEvents; e++) begin
         ev_inc[e] = event_inc[e*IncWidth +: IncWidth];
      end
   end

   assign sel_valid = (cfg.sel != 8'd0) && ({1'b0, cfg.sel} < SelLimit);
   assign blocked   = inhibit || debug_mode ||
                      (cfg.minh && (priv_lvl == 2'd3)) ||
                      (cfg.sinh && (priv_lvl == 2'd1)) ||
                      (cfg.uinh && (priv_lvl == 2'd0));
   assign inc       = (sel_valid && !blocked) ? ev_inc[cfg.sel[SelW-1:0]] : '0;
   assign sum       = {1'b0, cnt} + (CntWidth+1)'(inc);
   assign carry     = sum[CntWidth];
   assign cnt_we    = cnt_lo_we | cnt_hi_we;
   assign flag_we   = (XLEN == 64) ? evt_we : evt_hi_we;

   // Writes splice into a 64-bit image so the same code serves both halves and
   // any counter width; bits above CntWidth are simply dropped.
   always_comb begin
      wr_value = 64'(cnt);
      if (cnt_lo_we) wr_value[XLEN-1:0] = wdata;
      if (cnt_hi_we) wr_value[63:32]    = wdata[31:0];
   end

   assign cnt_next = cnt_we ? wr_value[CntWidth-1:0] : sum[CntWidth-1:0];

   always_comb begin
      cfg_next    = cfg;
      cfg_next.of = cfg.of | (carry & ~cnt_we);
      if (evt_we) cfg_next.sel = wdata[EVT_SEL_MSB:0];
      if (flag_we) begin
         cfg_next.of   = wdata[FlagTop];
         cfg_next.minh = wdata[FlagTop-1];
         cfg_next.sinh = wdata[FlagTop-2];
         cfg_next.uinh = wdata[FlagTop-3];
      end
   end

   assign of_rise = cfg_next.of & ~cfg.of;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         cfg <= '0;
      end else begin
         cnt <= cnt_next;
         cfg <= cfg_next;
      end
   end

   assign unused_bits = ^{wdata, wr_value};

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of NumCounters HPM counters behind the CSR port: address decode,
// access checking, read mux and the registered overflow interrupt pulse.
module hpm_counter_bank
   import hpm_counter_bank_pkg::*;
#(
   parameter int NumCounters = 6,
   parameter int CntWidth    = 64,
   parameter int NumEvents   = 32,
   parameter int IncWidth    = 2,
   parameter int XLEN        = 64
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   hpm_counter_bank_if.slave             csr,
   input  logic [NumEvents*IncWidth-1:0] event_inc_i,
   input  logic [1:0]                    priv_lvl_i,
   input  logic                          debug_mode_i,
   input  logic [NumCounters-1:0]        inhibit_i,
   output logic [NumCounters-1:0]        ovf_o,
   output logic                          ovf_irq_o
);

   localparam bit IsRv64  = (XLEN == 64);
   localparam int FlagTop = IsRv64 ? EVT_OF_BIT : EVTH_OF_BIT;

   logic                hit_mcnt, hit_mcnth, hit_ucnt, hit_ucnth, hit_evt, hit_evth;
   logic                hi_region, err, impl, wr_ok;
   logic [4:0]          kidx;
   logic [CntWidth-1:0] cnt_all [NumCounters];
   hpm_event_cfg_t      cfg_all [NumCounters];
   logic [NumCounters-1:0] of_rise;
   logic [63:0]         c64;
   logic [XLEN-1:0]     evt_lo, evt_hi, rdata;

   assign hit_mcnt  = page_hit(csr.addr_i, MHPMCOUNTER3);
   assign hit_mcnth = page_hit(csr.addr_i, MHPMCOUNTER3H);
   assign hit_ucnt  = page_hit(csr.addr_i, HPMCOUNTER3);
   assign hit_ucnth = page_hit(csr.addr_i, HPMCOUNTER3H);
   assign hit_evt   = page_hit(csr.addr_i, MHPMEVENT3);
   assign hit_evth  = page_hit(csr.addr_i, MHPMEVENT3H);

   assign kidx      = csr.addr_i[4:0] - 5'd3;
   assign impl      = kidx < 5'(NumCounters);
   assign hi_region = hit_mcnth | hit_ucnth | hit_evth;
   // User-mode shadows are read-only; upper halves do not exist on RV64.
   assign err       = (csr.we_i && (hit_ucnt || hit_ucnth)) || (IsRv64 && hi_region);
   assign wr_ok     = csr.we_i && !err && impl;

   for (genvar k = 0; k < NumCounters; k++) begin : g_slice
      logic sel_k;
      assign sel_k = wr_ok && (kidx == 5'(k));

      hpm_counter_slice #(
         .CntWidth  (CntWidth),
         .NumEvents (NumEvents),
         .IncWidth  (IncWidth),
         .XLEN      (XLEN)
      ) u_slice (
         .clk        (clk_i),
         .rst        (rst_i),
         .event_inc  (event_inc_i),
         .priv_lvl   (priv_lvl_i),
         .debug_mode (debug_mode_i),
         .inhibit    (inhibit_i[k]),
         .cnt_lo_we  (sel_k && hit_mcnt),
         .cnt_hi_we  (sel_k && hit_mcnth),
         .evt_we     (sel_k && hit_evt),
         .evt_hi_we  (sel_k && hit_evth),
         .wdata      (csr.data_i),
         .cnt        (cnt_all[k]),
         .cfg        (cfg_all[k]),
         .of_rise    (of_rise[k])
      );

      assign ovf_o[k] = cfg_all[k].of;
   end

   always_comb begin
      c64    = '0;
      evt_lo = '0;
      evt_hi = '0;
      rdata  = '0;
      for (int k = 0; k < NumCounters; k++) begin
         if (kidx == 5'(k)) begin
            c64                      = 64'(cnt_all[k]);
            evt_lo[EVT_SEL_MSB:0]    = cfg_all[k].sel;
            if (IsRv64) evt_lo[FlagTop -: 4] = {cfg_all[k].of, cfg_all[k].minh,
                                                cfg_all[k].sinh, cfg_all[k].uinh};
            evt_hi[FlagTop -: 4]     = {cfg_all[k].of, cfg_all[k].minh,
                                        cfg_all[k].sinh, cfg_all[k].uinh};
         end
      end
      if (!err && impl) begin
         if (hit_mcnt || hit_ucnt)        rdata = c64[XLEN-1:0];
         else if (hit_mcnth || hit_ucnth) rdata = XLEN'(c64[63:32]);
         else if (hit_evt)                rdata = evt_lo;
         else if (hit_evth)               rdata = evt_hi;
      end
   end

   assign csr.data_o       = rdata;
   assign csr.access_err_o = err;

   always_ff @(posedge clk_i) begin
      if (rst_i) ovf_irq_o <= 1'b0;
      else       ovf_irq_o <= |of_rise;
   end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank: an RV64/64-bit instance and an
// RV32/40-bit instance driven through a linear sequence of checked steps.
module tb_hpm_counter_bank;
   import hpm_counter_bank_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] ev64, ev32;
   logic [1:0]  priv;
   logic        debug;
   logic [5:0]  inhibit;
   logic [5:0]  ovf64, ovf32;
   logic        irq64, irq32;
   logic [63:0] rd;
   logic        er;
   int          testsRun = 0;
   int          testsFailed = 0;

   hpm_counter_bank_if #(.XLEN(64)) csr64 ();
   hpm_counter_bank_if #(.XLEN(32)) csr32 ();

   hpm_counter_bank #(.NumCounters(6), .CntWidth(64), .NumEvents(32), .IncWidth(2), .XLEN(64)) dut64 (
      .clk_i(clk), .rst_i(rst), .csr(csr64), .event_inc_i(ev64), .priv_lvl_i(priv),
      .debug_mode_i(debug), .inhibit_i(inhibit), .ovf_o(ovf64), .ovf_irq_o(irq64));

   hpm_counter_bank #(.NumCounters(6), .CntWidth(40), .NumEvents(32), .IncWidth(2), .XLEN(32)) dut32 (
      .clk_i(clk), .rst_i(rst), .csr(csr32), .event_inc_i(ev32), .priv_lvl_i(priv),
      .debug_mode_i(debug), .inhibit_i(inhibit), .ovf_o(ovf32), .ovf_irq_o(irq32));

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic wr64(input logic [11:0] a, input logic [63:0] d);
      @(negedge clk);
      csr64.addr_i = a; csr64.data_i = d; csr64.we_i = 1'b1;
      @(negedge clk);
      csr64.we_i = 1'b0;
   endtask

   task automatic wr32(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      csr32.addr_i = a; csr32.data_i = d; csr32.we_i = 1'b1;
      @(negedge clk);
      csr32.we_i = 1'b0;
   endtask

   task automatic rd64(input logic [11:0] a);
      csr64.addr_i = a; csr64.we_i = 1'b0;
      #1;
      rd = csr64.data_o; er = csr64.access_err_o;
   endtask

   task automatic rd32(input logic [11:0] a);
      csr32.addr_i = a; csr32.we_i = 1'b0;
      #1;
      rd = 64'(csr32.data_o); er = csr32.access_err_o;
   endtask

   // Drives one event's increment for a whole number of rising edges.
   task automatic applyStimulus(input bit wide, input int e, input logic [1:0] v, input int cycles);
      @(negedge clk);
      if (wide) ev64[e*2 +: 2] = v;
      else      ev32[e*2 +: 2] = v;
      repeat (cycles) @(negedge clk);
      ev64 = '0; ev32 = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; ev64 = '0; ev32 = '0; priv = 2'd0; debug = 1'b0; inhibit = '0;
      csr64.addr_i = '0; csr64.we_i = 1'b0; csr64.data_i = '0;
      csr32.addr_i = '0; csr32.we_i = 1'b0; csr32.data_i = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      checkOutput("reset_ovf64", 64'(ovf64), 64'd0);
      checkOutput("reset_irq64", 64'(irq64), 64'd0);
      rd64(MHPMCOUNTER3); checkOutput("reset_cnt0", rd, 64'd0);
      rd64(MHPMEVENT3);   checkOutput("reset_evt0", rd, 64'd0);

      // Counter wrap and single-cycle interrupt
      wr64(MHPMCOUNTER3, 64'hFFFF_FFFF_FFFF_FFFE);
      wr64(MHPMEVENT3, 64'd5);
      applyStimulus(1'b1, 5, 2'd3, 1);
      checkOutput("wrap_irq_high", 64'(irq64), 64'd1);
      checkOutput("wrap_ovf", 64'(ovf64), 64'd1);
      rd64(MHPMCOUNTER3); checkOutput("wrap_cnt", rd, 64'd1);
      @(negedge clk);
      checkOutput("wrap_irq_one_cycle", 64'(irq64), 64'd0);
      wr64(MHPMCOUNTER3, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(1'b1, 5, 2'd1, 1);
      checkOutput("rewrap_no_irq", 64'(irq64), 64'd0);
      rd64(MHPMCOUNTER3); checkOutput("rewrap_cnt", rd, 64'd0);
      rd64(MHPMEVENT3);   checkOutput("rewrap_evt", rd, 64'h8000_0000_0000_0005);

      // Write/increment collision
      wr64(MHPMEVENT3, 64'd1);
      checkOutput("of_sw_clear", 64'(ovf64), 64'd0);
      wr64(MHPMEVENT3 + 12'd1, 64'd1);
      wr64(MHPMCOUNTER3 + 12'd1, 64'd0);
      @(negedge clk);
      ev64[3:2] = 2'd2;
      csr64.addr_i = MHPMCOUNTER3; csr64.data_i = 64'd100; csr64.we_i = 1'b1;
      @(negedge clk);
      csr64.we_i = 1'b0;
      rd64(MHPMCOUNTER3);          checkOutput("collide_write_wins", rd, 64'd100);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("collide_other_cnt", rd, 64'd2);
      @(negedge clk);
      rd64(MHPMCOUNTER3);          checkOutput("collide_next_inc", rd, 64'd102);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("collide_other_next", rd, 64'd4);
      ev64 = '0;

      // Privilege filter, inhibit and debug freeze
      wr64(MHPMEVENT3, 64'h4000_0000_0000_0001);
      priv = 2'd3;
      applyStimulus(1'b1, 1, 2'd1, 2);
      rd64(MHPMCOUNTER3);          checkOutput("minh_m_frozen", rd, 64'd102);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("minh_other_counts", rd, 64'd6);
      priv = 2'd0;
      applyStimulus(1'b1, 1, 2'd1, 2);
      rd64(MHPMCOUNTER3);          checkOutput("minh_u_counts", rd, 64'd104);
      inhibit = 6'b000001;
      applyStimulus(1'b1, 1, 2'd1, 2);
      rd64(MHPMCOUNTER3);          checkOutput("inhibit_frozen", rd, 64'd104);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("inhibit_other", rd, 64'd10);
      inhibit = '0;
      debug = 1'b1;
      applyStimulus(1'b1, 1, 2'd1, 2);
      rd64(MHPMCOUNTER3);          checkOutput("debug_frozen0", rd, 64'd104);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("debug_frozen1", rd, 64'd10);
      debug = 1'b0;
      wr64(MHPMEVENT3 + 12'd1, 64'd32);
      applyStimulus(1'b1, 0, 2'd3, 1);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("sel_out_of_range", rd, 64'd10);

      // Access errors and unimplemented counters
      @(negedge clk);
      rd64(MHPMCOUNTER3H); checkOutput("rv64_cnth_err", 64'(er), 64'd1);
      checkOutput("rv64_cnth_data", rd, 64'd0);
      rd64(MHPMEVENT3H);   checkOutput("rv64_evth_err", 64'(er), 64'd1);
      @(negedge clk);
      csr64.addr_i = HPMCOUNTER3; csr64.data_i = 64'd555; csr64.we_i = 1'b1;
      #1;
      checkOutput("user_write_err", 64'(csr64.access_err_o), 64'd1);
      @(negedge clk);
      csr64.we_i = 1'b0;
      rd64(MHPMCOUNTER3);  checkOutput("user_write_ignored", rd, 64'd104);
      rd64(HPMCOUNTER3);   checkOutput("user_read_data", rd, 64'd104);
      checkOutput("user_read_no_err", 64'(er), 64'd0);
      @(negedge clk);
      rd64(12'hB1F);       checkOutput("unimpl_read", rd, 64'd0);
      checkOutput("unimpl_no_err", 64'(er), 64'd0);
      rd64(12'h300);       checkOutput("outside_no_err", 64'(er), 64'd0);

      // Narrow counter on RV32
      wr32(MHPMCOUNTER3, 32'hFFFF_FFFF);
      wr32(MHPMCOUNTER3H, 32'hFFFF_FFFF);
      rd32(MHPMCOUNTER3H); checkOutput("narrow_hi_masked", rd, 64'h0000_00FF);
      rd32(MHPMCOUNTER3);  checkOutput("narrow_lo", rd, 64'hFFFF_FFFF);
      checkOutput("rv32_cnth_no_err", 64'(er), 64'd0);
      wr32(MHPMEVENT3, 32'd5);
      applyStimulus(1'b0, 5, 2'd1, 1);
      checkOutput("narrow_irq", 64'(irq32), 64'd1);
      checkOutput("narrow_ovf", 64'(ovf32), 64'd1);
      rd32(MHPMCOUNTER3);  checkOutput("narrow_wrap_lo", rd, 64'd0);
      rd32(MHPMCOUNTER3H); checkOutput("narrow_wrap_hi", rd, 64'd0);
      rd32(MHPMEVENT3H);   checkOutput("narrow_evth_of", rd, 64'h8000_0000);
      wr32(MHPMEVENT3H, 32'h4000_0000);
      checkOutput("evth_clear_of", 64'(ovf32), 64'd0);
      rd32(MHPMEVENT3H);   checkOutput("evth_minh", rd, 64'h4000_0000);
      rd32(MHPMEVENT3);    checkOutput("rv32_evt_sel_only", rd, 64'd5);

      // Reset dominates a write and an overflowing increment
      wr64(MHPMEVENT3 + 12'd1, 64'd1);
      wr64(MHPMCOUNTER3 + 12'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      rst = 1'b1; ev64[3:2] = 2'd1;
      csr64.addr_i = MHPMCOUNTER3; csr64.data_i = 64'd55; csr64.we_i = 1'b1;
      @(negedge clk);
      rst = 1'b0; csr64.we_i = 1'b0; ev64 = '0;
      checkOutput("rst_irq", 64'(irq64), 64'd0);
      checkOutput("rst_ovf", 64'(ovf64), 64'd0);
      rd64(MHPMCOUNTER3);          checkOutput("rst_cnt0", rd, 64'd0);
      rd64(MHPMCOUNTER3 + 12'd1);  checkOutput("rst_cnt1", rd, 64'd0);
      rd64(MHPMEVENT3 + 12'd1);    checkOutput("rst_evt1", rd, 64'd0);
      @(negedge clk);
      rd32(MHPMEVENT3H);           checkOutput("rst_evth32", rd, 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
